// File: rtl/traffic_pkg.sv
// Shared types for the intersection sequencer.
//   light_t      : signal head colour, 2-bit encoding driven onto the light ports
//   phase_t      : sequencer state, 3-bit encoding exposed on the phase port
//   light_pair_t : NS/EW head colours for one phase
//   light_decode : phase -> head colours (Moore output decode)
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_TO_EW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_TO_NS = 3'd5
    } phase_t;

    typedef struct packed {
        light_t ns;
        light_t ew;
    } light_pair_t;

    // Any phase that is not an explicit green/yellow shows red on both heads,
    // which also covers the clearance phases and the two unused codes.
    function automatic light_pair_t light_decode(input phase_t p);
        light_pair_t r;
        r.ns = RED;
        r.ew = RED;
        case (p)
            NS_GREEN:  r.ns = GREEN;
            NS_YELLOW: r.ns = YELLOW;
            EW_GREEN:  r.ew = GREEN;
            EW_YELLOW: r.ew = YELLOW;
            default:   ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Cycles-in-state counter for the intersection sequencer.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, count -> 0
//   clear   : synchronous clear, takes priority over counting
//   count   : TW-bit count, saturates at all-ones
module phase_timer #(
    parameter int TW = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    output logic [TW-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != '1) begin
            // Saturate so a long-held green never wraps back below the
            // minimum/maximum green thresholds.
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Timed two-way intersection sequencer.
// Cycles NS green -> NS yellow -> all red -> EW green -> EW yellow -> all red,
// enforcing minimum/maximum green, yellow and all-red clearance times. Demand
// per direction is its car sensor OR its latched pedestrian request.
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset (-> NS_GREEN, timer 0, latches clear)
//   ns_car   : car present on north-south approach (level)
//   ew_car   : car present on east-west approach (level)
//   ns_ped   : pedestrian request along north-south (pulse or level)
//   ew_ped   : pedestrian request along east-west (pulse or level)
//   ns_light : NS head colour (0=RED, 1=YELLOW, 2=GREEN)
//   ew_light : EW head colour, same encoding
//   ns_walk  : NS walk, high throughout NS_GREEN
//   ew_walk  : EW walk, high throughout EW_GREEN
//   phase    : current state code, for debug and checking
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int TW        = 8,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ns_ped,
    input  logic       ew_ped,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       ns_walk,
    output logic       ew_walk,
    output logic [2:0] phase
);

    // Timer thresholds: cycle n of a state sees timer = n-1, so a phase of
    // length L ends on the cycle where timer == L-1.
    localparam logic [TW-1:0] MIN_T   = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_T   = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_T   = TW'(YELLOW - 1);
    localparam logic [TW-1:0] CLEAR_T = TW'(ALL_RED - 1);

    phase_t          state;
    phase_t          state_next;
    logic [TW-1:0]   timer;
    logic            state_change;
    logic            ns_ped_q;
    logic            ew_ped_q;
    logic            ns_dem;
    logic            ew_dem;
    logic            enter_ns_green;
    logic            enter_ew_green;
    light_pair_t     lights;

    assign ns_dem = ns_car | ns_ped_q;
    assign ew_dem = ew_car | ew_ped_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= NS_GREEN;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            NS_GREEN: begin
                // Yield only after minimum green, and only to real conflicting
                // demand; own demand holds the green until maximum green.
                if (timer >= MIN_T && ew_dem && (!ns_dem || timer >= MAX_T)) begin
                    state_next = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                if (timer == YEL_T) begin
                    state_next = RED_TO_EW;
                end
            end
            RED_TO_EW: begin
                if (timer == CLEAR_T) begin
                    state_next = EW_GREEN;
                end
            end
            EW_GREEN: begin
                if (timer >= MIN_T && ns_dem && (!ew_dem || timer >= MAX_T)) begin
                    state_next = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                if (timer == YEL_T) begin
                    state_next = RED_TO_NS;
                end
            end
            RED_TO_NS: begin
                if (timer == CLEAR_T) begin
                    state_next = NS_GREEN;
                end
            end
            default: begin
                // Unused codes recover to a known green on the next edge.
                state_next = NS_GREEN;
            end
        endcase
    end

    assign state_change   = (state_next != state);
    assign enter_ns_green = state_change && (state_next == NS_GREEN);
    assign enter_ew_green = state_change && (state_next == EW_GREEN);

    // ------------------------------------------------------------------
    // Cycles-in-state timer
    // ------------------------------------------------------------------
    phase_timer #(
        .TW (TW)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_change),
        .count   (timer)
    );

    // ------------------------------------------------------------------
    // Pedestrian request latches. A request during the direction's own
    // green is already being served and is dropped. Entering that green
    // clears the latch, and the clear wins over a same-cycle request.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ns_ped_q <= 1'b0;
            ew_ped_q <= 1'b0;
        end else begin
            if (enter_ns_green) begin
                ns_ped_q <= 1'b0;
            end else if (ns_ped && state != NS_GREEN) begin
                ns_ped_q <= 1'b1;
            end

            if (enter_ew_green) begin
                ew_ped_q <= 1'b0;
            end else if (ew_ped && state != EW_GREEN) begin
                ew_ped_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs: decoded from state only
    // ------------------------------------------------------------------
    assign lights   = light_decode(state);
    assign ns_light = lights.ns;
    assign ew_light = lights.ew;
    assign ns_walk  = (state == NS_GREEN);
    assign ew_walk  = (state == EW_GREEN);
    assign phase    = state;

endmodule
